// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the parametrised single-clock FIFO.
// The master drives the write data and the wr/rd requests. The slave (the FIFO) returns data and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] din;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output din, wr, rd,
    input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr, rd,
    output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, and overflow/underflow pulses. It offers a registered read mode or a
// first-word-fall-through read mode.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty, wr_acc, rd_acc;
  logic [DATA_W-1:0] head;

  // The status flags and the accept decisions come only from the registered count.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr && !full;
  assign rd_acc = bus.rd && !empty;
  assign head   = mem[rptr_q];

  // Compute the next pointers, the next occupancy, the read-data register and the error pulses.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block infers a latch.
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    overflow_d  = bus.wr && full;
    underflow_d = bus.rd && empty;
    if (wr_acc) wptr_d = wptr_q + PTR_W'(1);
    if (rd_acc) begin
      rptr_d  = rptr_q + PTR_W'(1);
      dout_d  = head;
      valid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register. A synchronous reset overrides any wr/rd in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples the values from before the edge.
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, written on an accepted write.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset, so it can map onto plain RAM. Stale contents are never presented as valid.
    if (!rst && wr_acc) mem[wptr_q] <= bus.din;
  end

  assign bus.dout         = FWFT ? head : dout_q;
  assign bus.valid        = FWFT ? !empty : valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
